// File: rtl/mux_nx1_rr_pipe.sv
// N-to-1 word selector with fixed or round-robin channel choice, feeding a
// one-entry registered output stage with valid/ready back-pressure.
module mux_nx1_rr_pipe #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sel_err
);

   localparam int unsigned SEL_N = 2**SEL_W;

   logic [SEL_N*WIDTH-1:0] dataPad;
   logic [SEL_N-1:0]       validPad;
   logic [WIDTH-1:0]       chanWord [SEL_N];
   logic [SEL_W-1:0]       lastGrant;
   logic [SEL_W-1:0]       rrCand;
   logic                   rrFound;
   logic [SEL_W-1:0]       candidate;
   logic                   selOk;
   logic                   load;
   logic                   grant;
   logic                   selErrNext;

   // Pad sources out to the full select space so every index is in range.
   assign dataPad  = (SEL_N*WIDTH)'(in_data);
   assign validPad = SEL_N'(in_valid);

   for (genvar g = 0; g < SEL_N; g++) begin : gWord
      assign chanWord[g] = dataPad[g*WIDTH +: WIDTH];
   end

   // Round-robin search starts after the last grant, wrapping modulo CHANNELS.
   always_comb begin
      int unsigned idx;
      rrFound = 1'b0;
      rrCand  = '0;
      idx     = 0;
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
         idx = 32'(lastGrant) + k;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!rrFound && validPad[SEL_W'(idx)]) begin
            rrFound = 1'b1;
            rrCand  = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      load       = !out_valid || out_ready;
      selOk      = (32'(sel) < CHANNELS);
      candidate  = mode ? rrCand : sel;
      grant      = rst_n && load && (mode ? rrFound : (selOk && validPad[sel]));
      selErrNext = !mode && !selOk && load;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : gReady
      assign in_ready[g] = grant && (candidate == SEL_W'(g));
   end

   // Output stage and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         sel_err   <= 1'b0;
         lastGrant <= SEL_W'(CHANNELS - 1);
      end else begin
         sel_err <= selErrNext;
         if (load) begin
            out_valid <= grant;
            if (grant) begin
               out_data <= chanWord[candidate];
               out_chan <= candidate;
            end
         end
         if (grant && mode) lastGrant <= candidate;
      end
   end

endmodule

// File: tb/tb_mux_nx1_rr_pipe.sv
// Directed bench for mux_nx1_rr_pipe: a 4-channel and a 3-channel instance.
module tb_mux_nx1_rr_pipe;

   logic clk = 1'b0;
   logic rst_n;

   logic        mode4, outReady4, outValid4, selErr4;
   logic [1:0]  sel4, outChan4;
   logic [63:0] inData4;
   logic [3:0]  inValid4, inReady4;
   logic [15:0] outData4;

   logic        mode3, outReady3, outValid3, selErr3;
   logic [1:0]  sel3, outChan3;
   logic [47:0] inData3;
   logic [2:0]  inValid3, inReady3;
   logic [15:0] outData3;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clk = ~clk;

   mux_nx1_rr_pipe #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
      .in_data(inData4), .in_valid(inValid4), .in_ready(inReady4),
      .out_data(outData4), .out_chan(outChan4), .out_valid(outValid4),
      .out_ready(outReady4), .sel_err(selErr4)
   );

   mux_nx1_rr_pipe #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_data(inData3), .in_valid(inValid3), .in_ready(inReady3),
      .out_data(outData3), .out_chan(outChan3), .out_valid(outValid3),
      .out_ready(outReady3), .sel_err(selErr3)
   );

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mode4     = 1'b1; sel4 = 2'd0; inData4 = '0; inValid4 = 4'hF; outReady4 = 1'b1;
      mode3     = 1'b0; sel3 = 2'd0; inData3 = '0; inValid3 = 3'b000; outReady3 = 1'b1;
      step();
      step();
      // Reset state
      checkEq("rst_out_valid", 32'(outValid4), 32'd0);
      checkEq("rst_out_data",  32'(outData4),  32'd0);
      checkEq("rst_out_chan",  32'(outChan4),  32'd0);
      checkEq("rst_sel_err",   32'(selErr4),   32'd0);
      checkEq("rst_in_ready",  32'(inReady4),  32'd0);

      // Fixed select of channel 2
      rst_n    = 1'b1;
      mode4    = 1'b0; sel4 = 2'd2; inValid4 = 4'b0100;
      inData4  = {16'h0000, 16'hA5A5, 16'h0000, 16'h0000};
      #1;
      checkEq("fix_in_ready", 32'(inReady4), 32'h4);
      step();
      checkEq("fix_out_valid", 32'(outValid4), 32'd1);
      checkEq("fix_out_data",  32'(outData4),  32'hA5A5);
      checkEq("fix_out_chan",  32'(outChan4),  32'd2);
      inValid4 = 4'b0000;
      #1;
      checkEq("fix_idle_ready", 32'(inReady4), 32'd0);
      step();
      checkEq("bubble_valid", 32'(outValid4), 32'd0);
      checkEq("bubble_hold",  32'(outData4),  32'hA5A5);

      // Round-robin, all channels valid; pointer still at 3 after mode-0 use
      mode4    = 1'b1; inValid4 = 4'hF;
      inData4  = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      for (int k = 0; k < 8; k++) begin
         #1;
         checkEq("rr_in_ready", 32'(inReady4), 32'(4'b0001 << (k % 4)));
         step();
         checkEq("rr_out_valid", 32'(outValid4), 32'd1);
         checkEq("rr_out_chan",  32'(outChan4),  32'(k % 4));
         checkEq("rr_out_data",  32'(outData4),  32'((k % 4) * 16'h1111));
      end

      // Move pointer to 1, then alternate between channels 3 and 1
      inValid4 = 4'b0010;
      step();
      checkEq("rr_ptr_set", 32'(outChan4), 32'd1);
      inValid4 = 4'b1010;
      #1;
      checkEq("rr1010_r0", 32'(inReady4), 32'h8);
      step();
      checkEq("rr1010_c0", 32'(outChan4), 32'd3);
      checkEq("rr1010_r1", 32'(inReady4), 32'h2);
      step();
      checkEq("rr1010_c1", 32'(outChan4), 32'd1);
      checkEq("rr1010_r2", 32'(inReady4), 32'h8);
      step();
      checkEq("rr1010_c2", 32'(outChan4), 32'd3);

      // Back-pressure: 0x1234 held while ch0 offers 0x5678
      mode4   = 1'b0; sel4 = 2'd0; inValid4 = 4'b0001;
      inData4 = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
      step();
      checkEq("bp_load", 32'(outData4), 32'h1234);
      outReady4 = 1'b0;
      inData4   = {16'h0000, 16'h0000, 16'h0000, 16'h5678};
      for (int k = 0; k < 3; k++) begin
         #1;
         checkEq("bp_in_ready", 32'(inReady4), 32'd0);
         step();
         checkEq("bp_data",  32'(outData4),  32'h1234);
         checkEq("bp_valid", 32'(outValid4), 32'd1);
      end
      outReady4 = 1'b1;
      #1;
      checkEq("bp_release_ready", 32'(inReady4), 32'h1);
      step();
      checkEq("bp_next_data",  32'(outData4),  32'h5678);
      checkEq("bp_next_valid", 32'(outValid4), 32'd1);

      // Three-channel instance: out-of-range select
      mode3 = 1'b0; sel3 = 2'd3; inValid3 = 3'b111;
      inData3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      #1;
      checkEq("c3_bad_ready", 32'(inReady3), 32'd0);
      step();
      checkEq("c3_err0",   32'(selErr3),   32'd1);
      checkEq("c3_valid0", 32'(outValid3), 32'd0);
      step();
      checkEq("c3_err1",   32'(selErr3),   32'd1);
      checkEq("c3_valid1", 32'(outValid3), 32'd0);
      sel3 = 2'd0;
      step();
      checkEq("c3_err_clear", 32'(selErr3),   32'd0);
      checkEq("c3_sel0_data", 32'(outData3),  32'hAAAA);
      outReady3 = 1'b0; sel3 = 2'd3;
      step();
      checkEq("c3_err_noload", 32'(selErr3),  32'd0);
      checkEq("c3_hold_valid", 32'(outValid3), 32'd1);

      // Three-channel round-robin wrap 2 -> 0, and lone channel 2 after grant 2
      outReady3 = 1'b1; mode3 = 1'b1;
      step();
      checkEq("c3_rr_c0", 32'(outChan3), 32'd0);
      step();
      checkEq("c3_rr_c1", 32'(outChan3), 32'd1);
      step();
      checkEq("c3_rr_c2", 32'(outChan3), 32'd2);
      step();
      checkEq("c3_rr_wrap", 32'(outChan3), 32'd0);
      step();
      checkEq("c3_rr_c1b", 32'(outChan3), 32'd1);
      step();
      checkEq("c3_rr_c2b", 32'(outChan3), 32'd2);
      inValid3 = 3'b100;
      #1;
      checkEq("c3_rr_self_ready", 32'(inReady3), 32'h4);
      step();
      checkEq("c3_rr_self_chan", 32'(outChan3),  32'd2);
      checkEq("c3_rr_self_data", 32'(outData3),  32'hCCCC);

      // Reset while a word is stalled; pointer must return to CHANNELS-1
      mode4 = 1'b1; inValid4 = 4'hF;
      inData4 = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      step();
      checkEq("rst_pre_chan", 32'(outChan4), 32'd0);
      outReady4 = 1'b0;
      inData4   = {16'h3333, 16'h2222, 16'h1111, 16'h9999};
      step();
      checkEq("rst_pre_stall", 32'(outValid4), 32'd1);
      rst_n = 1'b0;
      #1;
      checkEq("rst_mid_ready", 32'(inReady4), 32'd0);
      step();
      checkEq("rst_mid_valid", 32'(outValid4), 32'd0);
      checkEq("rst_mid_data",  32'(outData4),  32'd0);
      checkEq("rst_mid_err",   32'(selErr4),   32'd0);
      rst_n = 1'b1; outReady4 = 1'b1;
      #1;
      checkEq("rst_post_ready", 32'(inReady4), 32'h1);
      step();
      checkEq("rst_post_chan", 32'(outChan4), 32'd0);
      checkEq("rst_post_data", 32'(outData4), 32'h9999);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/mux_nx1_rr_pipe.md
Name: mux_nx1_rr_pipe

Overview:
- Parametrised successor to the 4x1 mux used in the adder/subtractor datapath.
- Selects one of CHANNELS WIDTH-bit sources. Each source has its own valid/ready handshake.
- Two selection modes: fixed select, or round-robin among valid sources.
- The chosen word is registered into a one-entry output stage with valid/ready, so operand routing can be pipelined and back-pressured.

Parameters:
- WIDTH, 16, data bits per channel.
- CHANNELS, 4, number of input channels (legal range 2..2**SEL_W).
- SEL_W, 2, width of the select and channel-index fields.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept (combinational).
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accept.
- sel_err  output  1  registered one-cycle pulse: fixed-mode select out of range.

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, out_chan=0, sel_err=0, last_grant=CHANNELS-1. in_ready is all-zero while rst_n=0.
- load = !out_valid || out_ready. The output register may be written this cycle.
- Fixed mode (mode=0): candidate = sel.
  - If sel >= CHANNELS: no grant; all in_ready=0; sel_err=1 on the next cycle, only if load=1.
  - Otherwise grant = load && in_valid[sel].
- Round-robin mode (mode=1): candidate = first i with in_valid[i]=1, searching last_grant+1, last_grant+2, … modulo CHANNELS, with last_grant itself searched last.
  - grant = load && any in_valid.
  - last_grant <= candidate on each grant in mode 1 only.
  - last_grant is held across mode-0 cycles.
- in_ready[i] = grant && (i == candidate). At most one bit is set. The signal may depend on in_valid; valid must not depend on ready.
- Transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a grant, at the clock edge: out_data <= channel word, out_chan <= candidate, out_valid <= 1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready=1.
- If load=1 and there is no grant: out_valid <= 0 and out_data/out_chan hold their values.
- If out_valid=1 and out_ready=0: output is frozen (data, chan, valid stable), all in_ready=0, last_grant unchanged.
- Simultaneous out_ready=1 and new grant: old word leaves and new word loads on the same edge (no bubble).
- mode or sel changes take effect on the same cycle's selection. There is no internal select register; the output register is never corrupted by a change.
- Reset asserted mid-transfer: the pending output word is discarded, out_valid=0 next cycle, and the round-robin pointer returns to CHANNELS-1 (channel 0 highest priority).
- No arithmetic. Index wrap is modulo CHANNELS, not 2**SEL_W, when CHANNELS is not a power of two.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2=16'hA5A5, out_ready=1. Required: in_ready=4'b0100 the same cycle; next cycle out_valid=1, out_data=A5A5, out_chan=2.
- mode=1, all in_valid=1, ch0..3=0x0000,0x1111,0x2222,0x3333, out_ready=1 for 8 cycles. Required: out_chan sequence 0,1,2,3,0,1,2,3 and out_data matching, one word per cycle.
- mode=1, in_valid=4'b1010, last_grant=1. Required: grant ch3, then ch1, then ch3. Channels 0 and 2 never granted.
- Back-pressure: word 0x1234 in output, out_ready=0 for 3 cycles with ch0 valid. Required: out_data=1234 stable, in_ready=0. When out_ready rises, ch0 is accepted on the same edge the old word leaves.
- CHANNELS=3, SEL_W=2, mode=0, sel=3, in_valid=3'b111. Required: in_ready=0, out_valid stays 0, sel_err pulses 1 for one cycle per load cycle. Separately in round-robin mode, the pointer wraps 2 -> 0.
- rst_n=0 for one cycle while out_valid=1 and out_ready=0. Required: out_valid=0, out_data=0, sel_err=0 after the edge. The next round-robin grant goes to ch0 when all channels are valid.
